// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared definitions for the register bank: address-region decode helper,
//   offsets of the optional STATUS/MASK words (relative to N_RW+N_RO), and
//   the legacy top-level wrapper structs for the default 4x32 configuration.
//   The STATUS/MASK region is only decoded when the top is compiled with
//   REGBANK_IRQ_EN.
package register_bank_pkg;

    localparam int unsigned REGBANK_STATUS_OFS = 0;
    localparam int unsigned REGBANK_MASK_OFS   = 1;

    typedef enum logic [2:0] {
        REGION_RW,
        REGION_RO,
        REGION_STATUS,
        REGION_MASK,
        REGION_NONE
    } regionT;

    // Wrapper views of the packed buses at default parameters; word k sits in
    // slice [k*32 +: 32], so word0 is the least significant field.
    typedef struct packed {
        logic [31:0] word3;
        logic [31:0] word2;
        logic [31:0] word1;
        logic [31:0] word0;
    } WR_REGISTERS;

    typedef struct packed {
        logic [31:0] word3;
        logic [31:0] word2;
        logic [31:0] word1;
        logic [31:0] word0;
    } RD_REGISTERS;

    function automatic regionT decodeAddress(
        input int unsigned addr,
        input int unsigned nRw,
        input int unsigned nRo,
        input bit          irqEn
    );
        regionT region;
        if (addr < nRw)
            region = REGION_RW;
        else if (addr < nRw + nRo)
            region = REGION_RO;
        else if (irqEn && addr == nRw + nRo + REGBANK_STATUS_OFS)
            region = REGION_STATUS;
        else if (irqEn && addr == nRw + nRo + REGBANK_MASK_OFS)
            region = REGION_MASK;
        else
            region = REGION_NONE;
        return region;
    endfunction

endpackage

// File: rtl/regbank_sticky.sv
// regbank_sticky
//   Sticky event STATUS register, MASK register and registered interrupt.
//   ipClk/ipReset      : clock, async active-low reset
//   ipWrData/ipWrStrobe: host write data and byte-lane enables
//   ipStatusWr         : host write to STATUS (write-1-to-clear)
//   ipMaskWr           : host write to MASK
//   ipEvent            : event set pulses, one bit per STATUS bit
//   opStatus/opMask    : register contents for readback (STATUS zero-extended)
//   opIrq              : |(STATUS & MASK), registered
module regbank_sticky #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_EVT  = 8
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic [DATA_W-1:0]   ipWrData,
    input  logic [DATA_W/8-1:0] ipWrStrobe,
    input  logic                ipStatusWr,
    input  logic                ipMaskWr,
    input  logic [N_EVT-1:0]    ipEvent,
    output logic [DATA_W-1:0]   opStatus,
    output logic [DATA_W-1:0]   opMask,
    output logic                opIrq
);

    logic [N_EVT-1:0] status;
    logic [N_EVT-1:0] clearBits;

    always_comb begin
        clearBits = '0;
        if (ipStatusWr) begin
            for (int unsigned i = 0; i < N_EVT; i++)
                clearBits[i] = ipWrStrobe[i/8] & ipWrData[i];
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            status <= '0;
            opMask <= '0;
            opIrq  <= 1'b0;
        end else begin
            // Set is applied after clear so a coincident event wins.
            status <= (status & ~clearBits) | ipEvent;
            if (ipMaskWr) begin
                for (int unsigned b = 0; b < DATA_W/8; b++)
                    if (ipWrStrobe[b])
                        opMask[b*8 +: 8] <= ipWrData[b*8 +: 8];
            end
            opIrq <= |(status & opMask[N_EVT-1:0]);
        end
    end

    always_comb begin
        opStatus             = '0;
        opStatus[N_EVT-1:0]  = status;
    end

endmodule

// File: rtl/register_bank.sv
// register_bank
//   Memory-mapped register bank: N_RW byte-strobed RW registers with write
//   pulses, N_RO read-only inputs, registered reads with a valid pulse.
//   Optional sticky STATUS/MASK/interrupt logic when REGBANK_IRQ_EN is defined;
//   otherwise those addresses read 0, writes to them are ignored, opIrq is 0.
//   ipClk, ipReset        : clock, async active-low reset
//   ipAddress             : word address (reads and writes)
//   ipWrData/ipWrEnable/ipWrStrobe : write request
//   ipRdEnable            : read request; opRdData/opRdValid one cycle later
//   opWrRegs/opWrPulse    : RW register contents and per-register write pulse
//   ipRdRegs              : read-only values, sampled at read time
//   ipEvent/opIrq         : sticky event inputs and interrupt output
module register_bank
    import register_bank_pkg::*;
#(
    parameter int unsigned               DATA_W   = 32,
    parameter int unsigned               ADDR_W   = 8,
    parameter int unsigned               N_RW     = 4,
    parameter int unsigned               N_RO     = 4,
    parameter int unsigned               N_EVT    = 8,
    parameter logic [N_RW*DATA_W-1:0]    RW_RESET = '0
) (
    input  logic                     ipClk,
    input  logic                     ipReset,
    input  logic [ADDR_W-1:0]        ipAddress,
    input  logic [DATA_W-1:0]        ipWrData,
    input  logic                     ipWrEnable,
    input  logic [DATA_W/8-1:0]      ipWrStrobe,
    input  logic                     ipRdEnable,
    output logic [DATA_W-1:0]        opRdData,
    output logic                     opRdValid,
    output logic [N_RW*DATA_W-1:0]   opWrRegs,
    output logic [N_RW-1:0]          opWrPulse,
    input  logic [N_RO*DATA_W-1:0]   ipRdRegs,
    input  logic [N_EVT-1:0]         ipEvent,
    output logic                     opIrq
);

`ifdef REGBANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic [N_RW-1:0][DATA_W-1:0] wrRegs;
    logic [31:0]                 addrWide;
    regionT                      region;
    logic                        wrRw;
    logic [DATA_W-1:0]           rdMux;
    logic [DATA_W-1:0]           statusWord;
    logic [DATA_W-1:0]           maskWord;

    assign addrWide = 32'(ipAddress);
    assign region   = decodeAddress(addrWide, N_RW, N_RO, IRQ_EN);
    assign wrRw     = ipWrEnable && (region == REGION_RW);
    assign opWrRegs = wrRegs;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            for (int unsigned k = 0; k < N_RW; k++)
                wrRegs[k] <= RW_RESET[k*DATA_W +: DATA_W];
            opWrPulse <= '0;
        end else begin
            opWrPulse <= '0;
            for (int unsigned k = 0; k < N_RW; k++) begin
                if (wrRw && addrWide == k) begin
                    // Pulse fires even with all strobes low.
                    opWrPulse[k] <= 1'b1;
                    for (int unsigned b = 0; b < DATA_W/8; b++)
                        if (ipWrStrobe[b])
                            wrRegs[k][b*8 +: 8] <= ipWrData[b*8 +: 8];
                end
            end
        end
    end

    // Combinational source mux; same-cycle writes land after the read capture,
    // so a coincident read returns the pre-write value.
    always_comb begin
        rdMux = '0;
        case (region)
            REGION_RW: begin
                for (int unsigned k = 0; k < N_RW; k++)
                    if (addrWide == k)
                        rdMux = wrRegs[k];
            end
            REGION_RO: begin
                for (int unsigned j = 0; j < N_RO; j++)
                    if (addrWide == N_RW + j)
                        rdMux = ipRdRegs[j*DATA_W +: DATA_W];
            end
            REGION_STATUS: rdMux = statusWord;
            REGION_MASK:   rdMux = maskWord;
            default:       rdMux = '0;
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            opRdValid <= 1'b0;
            opRdData  <= '0;
        end else begin
            opRdValid <= ipRdEnable;
            if (ipRdEnable)
                opRdData <= rdMux;
        end
    end

`ifdef REGBANK_IRQ_EN
    regbank_sticky #(
        .DATA_W (DATA_W),
        .N_EVT  (N_EVT)
    ) uSticky (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipWrData   (ipWrData),
        .ipWrStrobe (ipWrStrobe),
        .ipStatusWr (ipWrEnable && (region == REGION_STATUS)),
        .ipMaskWr   (ipWrEnable && (region == REGION_MASK)),
        .ipEvent    (ipEvent),
        .opStatus   (statusWord),
        .opMask     (maskWord),
        .opIrq      (opIrq)
    );
`else
    logic unusedEvent;
    assign unusedEvent = ^ipEvent;
    assign statusWord  = '0;
    assign maskWord    = '0;
    assign opIrq       = 1'b0;
`endif

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank
//   Directed self-checking bench for register_bank at default parameters,
//   with RW register 1 resetting to 32'hFFFFF000. Covers the IRQ path when
//   REGBANK_IRQ_EN is defined, and the tied-off behaviour otherwise.
module tb_register_bank;

    localparam logic [127:0] RW_RST = {32'h0, 32'h0, 32'hFFFFF000, 32'h0};
    localparam logic [127:0] RO_VAL = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    logic         ipClk = 1'b0;
    logic         ipReset;
    logic [7:0]   ipAddress;
    logic [31:0]  ipWrData;
    logic         ipWrEnable;
    logic [3:0]   ipWrStrobe;
    logic         ipRdEnable;
    logic [31:0]  opRdData;
    logic         opRdValid;
    logic [127:0] opWrRegs;
    logic [3:0]   opWrPulse;
    logic [127:0] ipRdRegs;
    logic [7:0]   ipEvent;
    logic         opIrq;

    int vectors    = 0;
    int miscompares = 0;

    register_bank #(
        .DATA_W   (32),
        .ADDR_W   (8),
        .N_RW     (4),
        .N_RO     (4),
        .N_EVT    (8),
        .RW_RESET (RW_RST)
    ) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipAddress  (ipAddress),
        .ipWrData   (ipWrData),
        .ipWrEnable (ipWrEnable),
        .ipWrStrobe (ipWrStrobe),
        .ipRdEnable (ipRdEnable),
        .opRdData   (opRdData),
        .opRdValid  (opRdValid),
        .opWrRegs   (opWrRegs),
        .opWrPulse  (opWrPulse),
        .ipRdRegs   (ipRdRegs),
        .ipEvent    (ipEvent),
        .opIrq      (opIrq)
    );

    always #5 ipClk = ~ipClk;

    task automatic idleBus();
        ipWrEnable = 1'b0;
        ipRdEnable = 1'b0;
        ipWrStrobe = 4'h0;
        ipWrData   = 32'h0;
        ipEvent    = 8'h0;
    endtask

    task automatic test_reset();
        ipReset = 1'b1; ipAddress = 8'h0; ipRdRegs = RO_VAL; idleBus();
        #1 ipReset = 1'b0;
        #1;
        vectors++; if (opWrRegs !== RW_RST) begin miscompares++; $display("FAIL reset_wrregs: got %h expected %h", opWrRegs, RW_RST); end
        vectors++; if (opRdValid !== 1'b0) begin miscompares++; $display("FAIL reset_rdvalid: got %b expected 0", opRdValid); end
        vectors++; if (opRdData !== 32'h0) begin miscompares++; $display("FAIL reset_rddata: got %h expected 0", opRdData); end
        vectors++; if (opWrPulse !== 4'h0) begin miscompares++; $display("FAIL reset_pulse: got %b expected 0000", opWrPulse); end
        vectors++; if (opIrq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", opIrq); end
        @(negedge ipClk); ipReset = 1'b1;
        @(negedge ipClk); ipAddress = 8'd1; ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdValid !== 1'b1) begin miscompares++; $display("FAIL rd1_valid: got %b expected 1", opRdValid); end
        vectors++; if (opRdData !== 32'hFFFFF000) begin miscompares++; $display("FAIL rd1_data: got %h expected fffff000", opRdData); end
        vectors++; if (opWrPulse !== 4'h0) begin miscompares++; $display("FAIL rd1_pulse: got %b expected 0000", opWrPulse); end
        @(negedge ipClk); idleBus();
        @(posedge ipClk); #1;
        vectors++; if (opRdValid !== 1'b0) begin miscompares++; $display("FAIL rd1_valid_drop: got %b expected 0", opRdValid); end
        vectors++; if (opRdData !== 32'hFFFFF000) begin miscompares++; $display("FAIL rd1_data_hold: got %h expected fffff000", opRdData); end
    endtask

    task automatic test_strobe_write();
        @(negedge ipClk); ipAddress = 8'd2; ipWrData = 32'hAABBCCDD; ipWrStrobe = 4'b0101; ipWrEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opWrPulse !== 4'b0100) begin miscompares++; $display("FAIL strb_pulse: got %b expected 0100", opWrPulse); end
        vectors++; if (opWrRegs[95:64] !== 32'h00BB00DD) begin miscompares++; $display("FAIL strb_reg2: got %h expected 00bb00dd", opWrRegs[95:64]); end
        @(negedge ipClk); idleBus(); ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opWrPulse !== 4'b0000) begin miscompares++; $display("FAIL strb_pulse_width: got %b expected 0000", opWrPulse); end
        vectors++; if (opRdData !== 32'h00BB00DD || opRdValid !== 1'b1) begin miscompares++; $display("FAIL strb_read: got %h/%b expected 00bb00dd/1", opRdData, opRdValid); end
        // zero-strobe write still pulses but changes nothing
        @(negedge ipClk); idleBus(); ipAddress = 8'd3; ipWrData = 32'hFFFFFFFF; ipWrStrobe = 4'b0000; ipWrEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opWrPulse !== 4'b1000) begin miscompares++; $display("FAIL zstrb_pulse: got %b expected 1000", opWrPulse); end
        vectors++; if (opWrRegs[127:96] !== 32'h0) begin miscompares++; $display("FAIL zstrb_reg3: got %h expected 0", opWrRegs[127:96]); end
        @(negedge ipClk); idleBus();
    endtask

    task automatic test_same_cycle();
        @(negedge ipClk); ipAddress = 8'd0; ipWrData = 32'h12345678; ipWrStrobe = 4'hF; ipWrEnable = 1'b1; ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h0 || opRdValid !== 1'b1) begin miscompares++; $display("FAIL rw_same_old: got %h/%b expected 0/1", opRdData, opRdValid); end
        vectors++; if (opWrPulse !== 4'b0001) begin miscompares++; $display("FAIL rw_same_pulse: got %b expected 0001", opWrPulse); end
        @(negedge ipClk); ipWrEnable = 1'b0;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h12345678) begin miscompares++; $display("FAIL rw_same_new: got %h expected 12345678", opRdData); end
        @(negedge ipClk); idleBus();
    endtask

    task automatic test_unmapped();
        logic [127:0] expRegs;
        expRegs = {32'h0, 32'h00BB00DD, 32'hFFFFF000, 32'h12345678};
        @(negedge ipClk); ipAddress = 8'd5; ipWrData = 32'hDEADBEEF; ipWrStrobe = 4'hF; ipWrEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opWrPulse !== 4'h0) begin miscompares++; $display("FAIL ro_wr_pulse: got %b expected 0000", opWrPulse); end
        @(negedge ipClk); ipAddress = 8'hF0;
        @(posedge ipClk); #1;
        vectors++; if (opWrPulse !== 4'h0) begin miscompares++; $display("FAIL unm_wr_pulse: got %b expected 0000", opWrPulse); end
        vectors++; if (opWrRegs !== expRegs) begin miscompares++; $display("FAIL unm_wr_regs: got %h expected %h", opWrRegs, expRegs); end
        @(negedge ipClk); idleBus(); ipAddress = 8'd5; ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h22222222) begin miscompares++; $display("FAIL ro_rd5: got %h expected 22222222", opRdData); end
        @(negedge ipClk); ipAddress = 8'hF0;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h0 || opRdValid !== 1'b1) begin miscompares++; $display("FAIL unm_rd: got %h/%b expected 0/1", opRdData, opRdValid); end
        @(negedge ipClk); idleBus();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [6];
        logic [31:0] exps  [6];
        addrs = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd7, 8'd3};
        exps  = '{32'h12345678, 32'hFFFFF000, 32'h00BB00DD, 32'h11111111, 32'h44444444, 32'h0};
        for (int i = 0; i < 6; i++) begin
            @(negedge ipClk); ipAddress = addrs[i]; ipRdEnable = 1'b1;
            @(posedge ipClk); #1;
            vectors++; if (opRdValid !== 1'b1 || opRdData !== exps[i]) begin miscompares++; $display("FAIL b2b_rd%0d: got %h/%b expected %h/1", i, opRdData, opRdValid, exps[i]); end
        end
        @(negedge ipClk); idleBus();
        @(posedge ipClk); #1;
        vectors++; if (opRdValid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop: got %b expected 0", opRdValid); end
    endtask

`ifdef REGBANK_IRQ_EN
    task automatic test_irq();
        @(negedge ipClk); ipAddress = 8'd9; ipWrData = 32'h1; ipWrStrobe = 4'hF; ipWrEnable = 1'b1;
        @(negedge ipClk); idleBus(); ipEvent = 8'h01;
        @(posedge ipClk); #1;
        vectors++; if (opIrq !== 1'b0) begin miscompares++; $display("FAIL irq_lat1: got %b expected 0", opIrq); end
        @(negedge ipClk); ipEvent = 8'h00;
        @(posedge ipClk); #1;
        vectors++; if (opIrq !== 1'b1) begin miscompares++; $display("FAIL irq_lat2: got %b expected 1", opIrq); end
        // clear coincident with a new event: set wins
        @(negedge ipClk); ipAddress = 8'd8; ipWrData = 32'h1; ipWrStrobe = 4'hF; ipWrEnable = 1'b1; ipEvent = 8'h01;
        @(negedge ipClk); idleBus(); ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h1) begin miscompares++; $display("FAIL irq_setwins: got %h expected 1", opRdData); end
        // clear with the lane strobe off has no effect
        @(negedge ipClk); idleBus(); ipWrData = 32'h1; ipWrStrobe = 4'b1110; ipWrEnable = 1'b1;
        @(negedge ipClk); idleBus(); ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h1) begin miscompares++; $display("FAIL irq_nostrb: got %h expected 1", opRdData); end
        @(negedge ipClk); idleBus(); ipWrData = 32'h1; ipWrStrobe = 4'hF; ipWrEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opIrq !== 1'b1) begin miscompares++; $display("FAIL irq_clr_lat: got %b expected 1", opIrq); end
        @(negedge ipClk); idleBus(); ipRdEnable = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opIrq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b expected 0", opIrq); end
        vectors++; if (opRdData !== 32'h0) begin miscompares++; $display("FAIL status_cleared: got %h expected 0", opRdData); end
        @(negedge ipClk); ipAddress = 8'd9;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h1) begin miscompares++; $display("FAIL mask_rd: got %h expected 1", opRdData); end
        @(negedge ipClk); idleBus();
    endtask
`else
    task automatic test_irq();
        @(negedge ipClk); ipAddress = 8'd9; ipWrData = 32'hFFFFFFFF; ipWrStrobe = 4'hF; ipWrEnable = 1'b1; ipEvent = 8'hFF;
        @(negedge ipClk); idleBus(); ipAddress = 8'd8; ipRdEnable = 1'b1; ipEvent = 8'hFF;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h0 || opRdValid !== 1'b1) begin miscompares++; $display("FAIL noirq_status: got %h/%b expected 0/1", opRdData, opRdValid); end
        @(negedge ipClk); ipAddress = 8'd9;
        @(posedge ipClk); #1;
        vectors++; if (opRdData !== 32'h0) begin miscompares++; $display("FAIL noirq_mask: got %h expected 0", opRdData); end
        vectors++; if (opIrq !== 1'b0) begin miscompares++; $display("FAIL noirq_irq: got %b expected 0", opIrq); end
        @(negedge ipClk); idleBus();
    endtask
`endif

    task automatic test_reset_midread();
        @(negedge ipClk); ipAddress = 8'd0; ipRdEnable = 1'b1;
        #2 ipReset = 1'b0;
        #1;
        vectors++; if (opWrRegs !== RW_RST) begin miscompares++; $display("FAIL mid_rst_regs: got %h expected %h", opWrRegs, RW_RST); end
        vectors++; if (opRdData !== 32'h0 || opRdValid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_rd: got %h/%b expected 0/0", opRdData, opRdValid); end
        vectors++; if (opWrPulse !== 4'h0 || opIrq !== 1'b0) begin miscompares++; $display("FAIL mid_rst_misc: got %b/%b expected 0000/0", opWrPulse, opIrq); end
        @(posedge ipClk); #1;
        vectors++; if (opRdValid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_novalid: got %b expected 0", opRdValid); end
        ipRdEnable = 1'b0;
        @(negedge ipClk); ipReset = 1'b1;
        @(posedge ipClk); #1;
        vectors++; if (opRdValid !== 1'b0 || opRdData !== 32'h0) begin miscompares++; $display("FAIL post_rst_idle: got %h/%b expected 0/0", opRdData, opRdValid); end
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_same_cycle();
        test_unmapped();
        test_back_to_back();
        test_irq();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
